// File: rtl/line_gen_pkg.sv
// rtl/line_gen_pkg.sv - shared state and step-direction types for the line generator
package line_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_POS  = 2'sb01;
    localparam dir_t DIR_ZERO = 2'sb00;
    localparam dir_t DIR_NEG  = 2'sb11;

    function automatic dir_t dir_of(input logic neg, input logic zero);
        if (zero)
            return DIR_ZERO;
        else if (neg)
            return DIR_NEG;
        else
            return DIR_POS;
    endfunction

endpackage

// File: rtl/line_step_core.sv
// rtl/line_step_core.sv - combinational single Bresenham step (x, y, err) -> next point
module line_step_core
    import line_gen_pkg::*;
#(
    parameter int CW = 12,
    parameter int EW = CW + 2
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  dir_t                 sx,
    input  dir_t                 sy,
    output logic signed [CW-1:0] nx,
    output logic signed [CW-1:0] ny,
    output logic signed [EW-1:0] nerr,
    output logic                 y_step
);

    // e2 carries one extra bit so doubling err can never wrap
    logic signed [EW:0]   e2;
    logic signed [EW:0]   dx_w;
    logic signed [EW:0]   dy_w;
    logic signed [EW-1:0] add_x;
    logic signed [EW-1:0] add_y;
    logic signed [CW-1:0] sx_w;
    logic signed [CW-1:0] sy_w;
    logic                 x_step;

    always_comb begin
        e2     = {err, 1'b0};
        dx_w   = {dx[EW-1], dx};
        dy_w   = {dy[EW-1], dy};
        x_step = (e2 >= dy_w);
        y_step = (e2 <= dx_w);
        sx_w   = {{(CW-2){sx[1]}}, sx};
        sy_w   = {{(CW-2){sy[1]}}, sy};
        add_x  = x_step ? dy : {EW{1'b0}};
        add_y  = y_step ? dx : {EW{1'b0}};
        nerr   = err + add_x + add_y;
        nx     = x_step ? (x + sx_w) : x;
        ny     = y_step ? (y + sy_w) : y;
    end

endmodule

// File: rtl/bresenham_line_gen.sv
// rtl/bresenham_line_gen.sv - streaming Bresenham line rasteriser; optional clip window via LINE_GEN_CLIP_EN
module bresenham_line_gen
    import line_gen_pkg::*;
#(
    parameter int CW = 12,
    parameter int EW = CW + 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic signed [CW-1:0] ax,
    input  logic signed [CW-1:0] ay,
    input  logic signed [CW-1:0] bx,
    input  logic signed [CW-1:0] by,
`ifdef LINE_GEN_CLIP_EN
    input  logic signed [CW-1:0] clip_x0,
    input  logic signed [CW-1:0] clip_y0,
    input  logic signed [CW-1:0] clip_x1,
    input  logic signed [CW-1:0] clip_y1,
`endif
    input  logic                 stop_y_en,
    input  logic                 resume,
    input  logic                 abort,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic signed [CW-1:0] pix_x,
    output logic signed [CW-1:0] pix_y,
    output logic                 pix_last,
    output logic                 busy,
    output logic                 y_stopped,
    output logic                 line_done
);

    state_t state, state_nxt;

    logic signed [CW-1:0] x_q, y_q, ex_q, ey_q;
    logic signed [EW-1:0] err_q, dx_q, dy_q;
    dir_t                 sx_q, sy_q;

    logic signed [EW-1:0] ax_w, ay_w, bx_w, by_w;
    logic signed [EW-1:0] ddx, ddy, adx, ady;
    dir_t                 sx_new, sy_new;

    logic signed [CW-1:0] nx, ny;
    logic signed [EW-1:0] nerr;
    logic                 core_y_step;

    logic in_draw, at_end, visible, advance;
    logic load, step_en, done_set;

    // endpoint deltas in EW bits: full-range CW endpoints cannot overflow
    always_comb begin
        ax_w   = EW'(ax);
        ay_w   = EW'(ay);
        bx_w   = EW'(bx);
        by_w   = EW'(by);
        ddx    = bx_w - ax_w;
        ddy    = by_w - ay_w;
        adx    = ddx[EW-1] ? -ddx : ddx;
        ady    = ddy[EW-1] ? -ddy : ddy;
        sx_new = dir_of(ddx[EW-1], ddx == '0);
        sy_new = dir_of(ddy[EW-1], ddy == '0);
    end

    line_step_core #(
        .CW (CW),
        .EW (EW)
    ) u_step (
        .x      (x_q),
        .y      (y_q),
        .err    (err_q),
        .dx     (dx_q),
        .dy     (dy_q),
        .sx     (sx_q),
        .sy     (sy_q),
        .nx     (nx),
        .ny     (ny),
        .nerr   (nerr),
        .y_step (core_y_step)
    );

`ifdef LINE_GEN_CLIP_EN
    logic signed [CW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx0_q <= '0;
            cy0_q <= '0;
            cx1_q <= '0;
            cy1_q <= '0;
        end else if (load) begin
            cx0_q <= clip_x0;
            cy0_q <= clip_y0;
            cx1_q <= clip_x1;
            cy1_q <= clip_y1;
        end
    end

    assign visible = (x_q >= cx0_q) && (x_q <= cx1_q) &&
                     (y_q >= cy0_q) && (y_q <= cy1_q);
`else
    assign visible = 1'b1;
`endif

    assign in_draw   = (state == DRAW);
    assign at_end    = (x_q == ex_q) && (y_q == ey_q);
    // clipped points step on their own; visible points wait for the consumer
    assign advance   = in_draw && (!visible || pix_ready);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign y_stopped = (state == HOLD);
    assign pix_valid = in_draw && visible;
    assign pix_last  = pix_valid && at_end;
    assign pix_x     = x_q;
    assign pix_y     = y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step_en   = 1'b0;
        done_set  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        load      = 1'b1;
                        state_nxt = DRAW;
                    end
                end
                DRAW: begin
                    if (advance && at_end) begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end else if (advance) begin
                        step_en = 1'b1;
                        if (core_y_step && stop_y_en)
                            state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (resume || !stop_y_en)
                        state_nxt = DRAW;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            ex_q  <= '0;
            ey_q  <= '0;
            err_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            sx_q  <= DIR_ZERO;
            sy_q  <= DIR_ZERO;
        end else if (load) begin
            x_q   <= ax;
            y_q   <= ay;
            ex_q  <= bx;
            ey_q  <= by;
            dx_q  <= adx;
            dy_q  <= -ady;
            err_q <= adx - ady;
            sx_q  <= sx_new;
            sy_q  <= sy_new;
        end else if (step_en) begin
            x_q   <= nx;
            y_q   <= ny;
            err_q <= nerr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            line_done <= 1'b0;
        else
            line_done <= done_set;
    end

endmodule

// File: tb/tb_bresenham_line_gen.sv
// tb/tb_bresenham_line_gen.sv - self-checking bench for bresenham_line_gen
module tb_bresenham_line_gen;

    localparam int CW = 12;

    logic                 clk, reset, cmd_valid, cmd_ready;
    logic signed [CW-1:0] ax, ay, bx, by, pix_x, pix_y;
    logic                 stop_y_en, resume, abort, pix_valid, pix_ready;
    logic                 pix_last, busy, y_stopped, line_done;
`ifdef LINE_GEN_CLIP_EN
    logic signed [CW-1:0] clip_x0, clip_y0, clip_x1, clip_y1;
`endif

    int checks   = 0;
    int failures = 0;
    int rx[$];
    int ry[$];

    typedef struct {
        int ax, ay, bx, by;
        int mode;
        int npix;
    } vec_t;

    vec_t vecs[9];
    int   exp_x[6];
    int   exp_y[6];

    bresenham_line_gen #(.CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
`ifdef LINE_GEN_CLIP_EN
        .clip_x0   (clip_x0),
        .clip_y0   (clip_y0),
        .clip_x1   (clip_x1),
        .clip_y1   (clip_y1),
`endif
        .stop_y_en (stop_y_en),
        .resume    (resume),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .y_stopped (y_stopped),
        .line_done (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int isgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // reference: integer error-term line walk from a to b, one point per entry
    task automatic ref_line(input int x0, input int y0, input int x1, input int y1);
        int ddx, ddy, stx, sty, e, e2, x, y;
        rx.delete();
        ry.delete();
        ddx = iabs(x1 - x0);
        ddy = -iabs(y1 - y0);
        stx = isgn(x1 - x0);
        sty = isgn(y1 - y0);
        e = ddx + ddy;
        x = x0;
        y = y0;
        for (int k = 0; k < 10000; k++) begin
            rx.push_back(x);
            ry.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; x += stx; end
            if (e2 <= ddx) begin e += ddx; y += sty; end
        end
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1);
        @(negedge clk);
        ax = CW'(x0);
        ay = CW'(y0);
        bx = CW'(x1);
        by = CW'(y1);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggling, 2: ready random
    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int mode, input int npix);
        int  idx, cyc, n, prev_y, hold_x, hold_y, hold_l;
        bit  stalled, fin;
        ref_line(x0, y0, x1, y1);
        n = rx.size();
        pix_ready = 1'b0;
        issue(x0, y0, x1, y1);
        chk("first_pix_latency", pix_valid, 1);
        idx = 0; cyc = 0; fin = 0; stalled = 0;
        prev_y = 0; hold_x = 0; hold_y = 0; hold_l = 0;
        while (!fin && cyc < 10000) begin
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((cyc % 2) == 0);
                default: pix_ready = ($urandom_range(99) < 60);
            endcase
            if (pix_valid) begin
                if (stalled) begin
                    chk("stall_x", pix_x, hold_x);
                    chk("stall_y", pix_y, hold_y);
                    chk("stall_last", pix_last, hold_l);
                end
                if (pix_ready) begin
                    if (idx < n) begin
                        chk("pix_x", pix_x, rx[idx]);
                        chk("pix_y", pix_y, ry[idx]);
                    end
                    chk("pix_last", pix_last, (idx == n - 1) ? 1 : 0);
                    if (idx > 0 && y1 >= y0)
                        chk("y_monotonic", (pix_y >= prev_y) ? 1 : 0, 1);
                    prev_y = pix_y;
                    if (pix_last) fin = 1;
                    idx++;
                    if (idx > n + 4) fin = 1;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_x = pix_x;
                    hold_y = pix_y;
                    hold_l = pix_last;
                end
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("line_timeout", fin, 1);
        chk("pix_count", idx, npix);
        chk("line_done_pulse", line_done, 1);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("valid_drop", pix_valid, 0);
        pix_ready = 1'b0;
        @(negedge clk);
        chk("line_done_single", line_done, 0);
    endtask

    initial begin
        int x0, y0, x1, y1, seen, nclip, seen_last, done_seen;
        int cx[$];

        vecs[0] = '{0, 0, 5, 2, 2, 6};
        vecs[1] = '{3, 3, 3, 3, 0, 1};
        vecs[2] = '{10, 10, 7, 14, 1, 5};
        vecs[3] = '{0, 0, -7, 0, 2, 8};
        vecs[4] = '{0, 0, 0, -9, 1, 10};
        vecs[5] = '{-5, 5, 5, -5, 2, 11};
        vecs[6] = '{-2048, -2048, 2047, 2047, 0, 4096};
        vecs[7] = '{2047, -2048, -2048, -2045, 0, 4096};
        vecs[8] = '{1, -3, 4, 9, 2, 13};
        exp_x = '{0, 1, 2, 3, 4, 5};
        exp_y = '{0, 0, 1, 1, 2, 2};

        reset = 1'b1; cmd_valid = 1'b0; pix_ready = 1'b0;
        stop_y_en = 1'b0; resume = 1'b0; abort = 1'b0;
        ax = '0; ay = '0; bx = '0; by = '0;
`ifdef LINE_GEN_CLIP_EN
        clip_x0 = -12'sd2048; clip_y0 = -12'sd2048;
        clip_x1 = 12'sd2047;  clip_y1 = 12'sd2047;
`endif
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_y_stopped", y_stopped, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // exact pixel sequence against hand-derived constants
        pix_ready = 1'b1;
        issue(0, 0, 5, 2);
        for (int i = 0; i < 6; i++) begin
            chk("seq_valid", pix_valid, 1);
            chk("seq_x", pix_x, exp_x[i]);
            chk("seq_y", pix_y, exp_y[i]);
            chk("seq_last", pix_last, (i == 5) ? 1 : 0);
            @(negedge clk);
        end
        chk("seq_done", line_done, 1);
        chk("seq_idle", busy, 0);
        @(negedge clk);
        chk("seq_done_off", line_done, 0);

        for (int i = 0; i < 9; i++)
            run_line(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by, vecs[i].mode, vecs[i].npix);

        // Y-stop pause and resume
        stop_y_en = 1'b1;
        pix_ready = 1'b1;
        issue(0, 0, 2, 2);
        chk("hold_p0_x", pix_x, 0);
        @(negedge clk);
        chk("hold_stopped", y_stopped, 1);
        chk("hold_valid", pix_valid, 0);
        chk("hold_busy", busy, 1);
        @(negedge clk);
        chk("hold_stays", y_stopped, 1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_valid", pix_valid, 1);
        chk("resume_x", pix_x, 1);
        chk("resume_y", pix_y, 1);
        chk("resume_stopped", y_stopped, 0);
        @(negedge clk);
        chk("hold2_stopped", y_stopped, 1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume2_x", pix_x, 2);
        chk("resume2_last", pix_last, 1);
        @(negedge clk);
        chk("hold_line_done", line_done, 1);
        stop_y_en = 1'b0;
        pix_ready = 1'b0;
        @(negedge clk);

        // abort on the third pixel
        pix_ready = 1'b1;
        issue(0, 0, 100, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_third_x", pix_x, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pix_ready = 1'b0;
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_valid, 0);
        chk("abort_no_done", line_done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done_late", line_done, 0);
        end

        // reset in the middle of a line
        pix_ready = 1'b1;
        issue(0, 0, 50, 7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", pix_valid, 0);
        chk("midrst_x", pix_x, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_no_done", line_done, 0);
        @(negedge clk);
        chk("midrst_no_done_late", line_done, 0);
        pix_ready = 1'b0;

        for (int i = 0; i < 30; i++) begin
            x0 = int'($urandom_range(60)) - 30;
            y0 = int'($urandom_range(60)) - 30;
            x1 = int'($urandom_range(60)) - 30;
            y1 = int'($urandom_range(60)) - 30;
            seen = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
            run_line(x0, y0, x1, y1, 2, seen);
        end

`ifdef LINE_GEN_CLIP_EN
        clip_x0 = 12'sd0; clip_x1 = 12'sd1;
        clip_y0 = 12'sd0; clip_y1 = 12'sd0;
        pix_ready = 1'b1;
        issue(-2, 0, 2, 0);
        nclip = 0; seen_last = 0; done_seen = 0;
        for (int c = 0; c < 16 && done_seen == 0; c++) begin
            if (line_done) done_seen = 1;
            if (pix_valid) begin
                nclip++;
                cx.push_back(int'(pix_x));
                if (pix_last) seen_last = 1;
            end
            if (done_seen == 0) @(negedge clk);
        end
        chk("clip_count", nclip, 2);
        if (cx.size() == 2) begin
            chk("clip_x0", cx[0], 0);
            chk("clip_x1", cx[1], 1);
        end
        chk("clip_no_last", seen_last, 0);
        chk("clip_done", done_seen, 1);
        pix_ready = 1'b0;
        clip_x0 = -12'sd2048; clip_y0 = -12'sd2048;
        clip_x1 = 12'sd2047;  clip_y1 = 12'sd2047;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bresenham_line_gen.md
BRESENHAM_LINE_GEN -- requirements
Module: bresenham_line_gen

Interface
REQ-001 SHALL have parameter CW, default 12: signed coordinate width.
REQ-002 SHALL have parameter EW, default CW+2: signed error/delta width.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: line command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_ready && cmd_valid.
REQ-007 SHALL have ports ax, ay, bx, by, input, CW signed: line start and end points.
REQ-008 SHALL have port stop_y_en, input, 1: pause after every Y step.
REQ-009 SHALL have port resume, input, 1: leave the Y-stop pause.
REQ-010 SHALL have port abort, input, 1: cancel the current line.
REQ-011 SHALL have port pix_valid, output, 1: pixel offered.
REQ-012 SHALL have port pix_ready, input, 1: pixel consumed when pix_valid && pix_ready.
REQ-013 SHALL have ports pix_x, pix_y, output, CW signed: pixel coordinates.
REQ-014 SHALL have port pix_last, output, 1: the offered pixel equals (bx,by).
REQ-015 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-016 SHALL have port y_stopped, output, 1: high when the state is HOLD.
REQ-017 SHALL have port line_done, output, 1: one-cycle pulse when a line completes.

Function
REQ-018 SHALL implement states IDLE, DRAW and HOLD; cmd_ready SHALL equal (state==IDLE).
REQ-019 On accept, SHALL latch the endpoints.
  - sx/sy SHALL be +1, 0 or -1, taken from the sign of b-a.
  - dx SHALL be |bx-ax| and dy SHALL be -|by-ay|, computed in EW bits.
  - err SHALL be dx+dy.
  - Next state SHALL be DRAW.
REQ-020 In the cycle after accept, SHALL assert pix_valid with pix_x=ax and pix_y=ay (latency 1).
REQ-021 While pix_valid && !pix_ready, pix_x, pix_y and pix_last SHALL hold stable.
REQ-022 On each transfer of a non-last pixel, SHALL compute e2=2*err.
  - If e2>=dy: err+=dy and x+=sx.
  - If e2<=dx: err+=dx and y+=sy.
  - Both updates SHALL apply in the same cycle.
REQ-023 With pix_ready held high, SHALL sustain one pixel per cycle.
REQ-024 On transfer of a pix_last pixel:
  - next state SHALL be IDLE;
  - pix_valid SHALL drop;
  - line_done SHALL pulse for one cycle;
  - a new command SHALL be acceptable in that same cycle.
REQ-025 If ax==bx && ay==by, SHALL emit exactly one pixel, with pix_last high.
REQ-026 If a step changes y and stop_y_en=1, SHALL enter HOLD with pix_valid low and the new point retained.
  - HOLD SHALL go to DRAW on resume=1 or stop_y_en=0.
  - The new point SHALL be offered in the cycle after leaving HOLD.
REQ-027 abort SHALL take priority over every other event.
  - Next state SHALL be IDLE.
  - pix_valid SHALL drop.
  - line_done SHALL not pulse.
REQ-028 Endpoint deltas of full CW range SHALL be handled without overflow, as guaranteed by EW=CW+2.

Reset
REQ-029 On reset:
  - state SHALL be IDLE;
  - pix_valid, pix_last, busy, y_stopped and line_done SHALL be 0;
  - cmd_ready SHALL be 1;
  - pix_x, pix_y, err, dx and dy SHALL be 0.
REQ-030 Reset asserted mid-line SHALL discard the line with no line_done.

Configuration
REQ-031 With LINE_GEN_CLIP_EN defined, SHALL add CW-bit signed inputs clip_x0, clip_y0, clip_x1 and clip_y1, sampled at accept, forming an inclusive clip window.
  - Points outside the window SHALL be stepped internally at one per cycle with pix_valid low.
  - line_done SHALL still pulse at the endpoint when the endpoint is clipped.
  - pix_last SHALL appear only on an emitted endpoint.
REQ-032 Without LINE_GEN_CLIP_EN, the clip ports SHALL be absent and every point SHALL be emitted.

Structure
REQ-033 Package line_gen_pkg SHALL hold:
  - the state enum typedef (IDLE, DRAW, HOLD);
  - the direction constants DIR_POS, DIR_ZERO and DIR_NEG.
REQ-034 A combinational sub-module, line_step_core, SHALL compute the next (x, y, err) from (x, y, err, dx, dy, sx, sy).

Verification
REQ-035 With pix_ready=1, a (0,0)->(5,2) line SHALL emit (0,0), (1,0), (2,1), (3,1), (4,2), (5,2), with pix_last on (5,2) and line_done the following cycle.
REQ-036 A (3,3)->(3,3) line SHALL emit a single pixel with pix_last=1, then return to IDLE.
REQ-037 A (10,10)->(7,14) line with pix_ready toggling 1/0 SHALL hold coordinates stable while stalled and emit 5 pixels with y monotonically increasing.
REQ-038 With stop_y_en=1, a (0,0)->(2,2) line SHALL enter HOLD after each y step, with y_stopped=1.
  - A resume pulse SHALL offer the next point one cycle later.
REQ-039 abort asserted on the 3rd pixel of (0,0)->(100,0) SHALL give IDLE and cmd_ready=1 next cycle, with no line_done.
REQ-040 With LINE_GEN_CLIP_EN, a (-2,0)->(2,0) line with window x 0..1 SHALL emit only (0,0) and (1,0), with pix_last=0 and line_done pulsing after x=2.
